// File: rtl/count_task_scheduler.sv
// Two-requester round-robin scheduler sharing one up/down counter datapath.
// A granted task loads its start value and steps toward its end value, then pulses done.
module count_task_scheduler #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_start,
  input  logic [WIDTH-1:0] req0_end,
  input  logic             req0_up,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_start,
  input  logic [WIDTH-1:0] req1_end,
  input  logic             req1_up,
  input  logic             pause,
  input  logic             abort,
  output logic             busy,
  output logic             grant_id,
  output logic [WIDTH-1:0] count,
  output logic             done,
  output logic             done_aborted
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] start;
    logic [WIDTH-1:0] fin;
    logic             up;
  } task_t;

  state_t           state_q;
  task_t            task_q;
  task_t [1:0]      req;
  logic  [1:0]      vld;
  logic  [1:0]      rdy;
  logic             sel_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             grant_q, last_q, done_q, aborted_q;

  assign req[0] = '{start: req0_start, fin: req0_end, up: req0_up};
  assign req[1] = '{start: req1_start, fin: req1_end, up: req1_up};
  assign vld    = {req1_valid, req0_valid};

  // With both pending, the requester that did not win last time is picked.
  always_comb begin
    sel_d = 1'b0;
    if (&vld)        sel_d = ~last_q;
    else if (vld[1]) sel_d = 1'b1;
    rdy = 2'b00;
    if (state_q == IDLE) rdy[sel_d] = vld[sel_d];
  end

  always_comb begin
    count_d = task_q.up ? count_q + {{(WIDTH-1){1'b0}}, 1'b1}
                        : count_q - {{(WIDTH-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      task_q    <= '0;
      count_q   <= '0;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      case (state_q)
        IDLE: if (|rdy) begin
          task_q  <= req[sel_d];
          grant_q <= sel_d;
          last_q  <= sel_d;
          state_q <= LOAD;
        end
        LOAD: begin
          count_q <= task_q.start;
          state_q <= RUN;
        end
        RUN: begin
          if (abort) begin
            state_q   <= DONE;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
          end else if (count_q == task_q.fin) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (!pause) begin
            count_q <= count_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req0_ready   = rdy[0];
  assign req1_ready   = rdy[1];
  assign busy         = (state_q != IDLE);
  assign grant_id     = grant_q;
  assign count        = count_q;
  assign done         = done_q;
  assign done_aborted = aborted_q;

endmodule

// File: tb/tb_count_task_scheduler.sv
// Directed bench for count_task_scheduler; a done-monitor pops expected task results
// from a scoreboard queue filled when each task is issued.
module tb_count_task_scheduler;

  logic        clk, reset;
  logic        req0_valid, req0_ready, req0_up;
  logic [15:0] req0_start, req0_end;
  logic        req1_valid, req1_ready, req1_up;
  logic [15:0] req1_start, req1_end;
  logic        pause, abort, busy, grant_id, done, done_aborted;
  logic [15:0] count;

  typedef struct {
    logic        id;
    logic [15:0] cnt;
    logic        ab;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] seq_up[4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
  logic [15:0] seq_dn[4] = '{16'h0001, 16'h0000, 16'hFFFF, 16'hFFFE};
  int          ids[3]    = '{-1, -1, -1};
  int          hs_cyc[3] = '{-1, -1, -1};
  int          done_cyc;
  int          hs;

  count_task_scheduler #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_start(req0_start),
    .req0_end(req0_end), .req0_up(req0_up),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_start(req1_start),
    .req1_end(req1_end), .req1_up(req1_up),
    .pause(pause), .abort(abort), .busy(busy), .grant_id(grant_id),
    .count(count), .done(done), .done_aborted(done_aborted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a task, wait (bounded) for the handshake, and leave the DUT in LOAD.
  task automatic issue(input logic id, input logic [15:0] s, input logic [15:0] e,
                       input logic up, input bit push, input logic [15:0] fc, input logic ab);
    bit got;
    got = 0;
    if (id) begin
      req1_start = s; req1_end = e; req1_up = up; req1_valid = 1'b1;
    end else begin
      req0_start = s; req0_end = e; req0_up = up; req0_valid = 1'b1;
    end
    #1;
    for (int i = 0; i < 20; i++) begin
      if (id ? req1_ready : req0_ready) begin
        got = 1;
        break;
      end
      step();
    end
    chk("handshake", {31'd0, got}, 32'd1);
    if (push) sb.push_back('{id, fc, ab});
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30 && busy; i++) step();
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_count(input logic [15:0] v);
    for (int i = 0; i < 30 && count !== v; i++) step();
    chk("reach_count", {16'd0, count}, {16'd0, v});
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_grant", {31'd0, grant_id}, {31'd0, mon_e.id});
        chk("sb_count", {16'd0, count}, {16'd0, mon_e.cnt});
        chk("sb_aborted", {31'd0, done_aborted}, {31'd0, mon_e.ab});
      end
    end
  end

  initial begin
    reset = 1'b1; pause = 1'b0; abort = 1'b0;
    req0_valid = 1'b0; req0_start = '0; req0_end = '0; req0_up = 1'b0;
    req1_valid = 1'b0; req1_start = '0; req1_end = '0; req1_up = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_count", {16'd0, count}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_grant", {31'd0, grant_id}, 32'd0);

    // Basic up task: ready on the first cycle, done at T+6.
    req0_start = 16'h0005; req0_end = 16'h0008; req0_up = 1'b1; req0_valid = 1'b1;
    #1;
    chk("t1_ready0", {31'd0, req0_ready}, 32'd1);
    chk("t1_ready1", {31'd0, req1_ready}, 32'd0);
    sb.push_back('{1'b0, 16'h0008, 1'b0});
    step();
    req0_valid = 1'b0;
    chk("t1_load_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t1_count", {16'd0, count}, 32'd5 + i);
      chk("t1_nodone", {31'd0, done}, 32'd0);
    end
    step();
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_ab", {31'd0, done_aborted}, 32'd0);
    chk("t1_grant", {31'd0, grant_id}, 32'd0);
    step();
    chk("t1_idle", {31'd0, busy}, 32'd0);
    chk("t1_done_low", {31'd0, done}, 32'd0);

    // Round-robin with both continuously valid from reset.
    reset = 1'b1; step(); reset = 1'b0;
    req0_start = 16'h0100; req0_end = 16'h0102; req0_up = 1'b1; req0_valid = 1'b1;
    req1_start = 16'h0200; req1_end = 16'h01FE; req1_up = 1'b0; req1_valid = 1'b1;
    hs = 0; done_cyc = -1;
    for (int c = 0; c < 60 && hs < 3; c++) begin
      #1;
      chk("rr_onehot", {31'd0, req0_ready & req1_ready}, 32'd0);
      if (done && done_cyc < 0) done_cyc = c;
      if (req0_ready) begin
        ids[hs] = 0; hs_cyc[hs] = c; hs++;
        sb.push_back('{1'b0, 16'h0102, 1'b0});
      end else if (req1_ready) begin
        ids[hs] = 1; hs_cyc[hs] = c; hs++;
        sb.push_back('{1'b1, 16'h01FE, 1'b0});
      end
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rr_hs_count", hs, 32'd3);
    chk("rr_id0", ids[0], 32'd0);
    chk("rr_id1", ids[1], 32'd1);
    chk("rr_id2", ids[2], 32'd0);
    chk("rr_back2back", hs_cyc[1], done_cyc + 1);
    chk("rr_period", hs_cyc[1] - hs_cyc[0], 32'd6);
    wait_idle();

    // Wrap-around up then down on requester 1.
    issue(1'b1, 16'hFFFE, 16'h0001, 1'b1, 1, 16'h0001, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("wrap_up", {16'd0, count}, {16'd0, seq_up[i]});
    end
    step();
    chk("wrap_up_done", {31'd0, done}, 32'd1);
    step();
    issue(1'b1, 16'h0001, 16'hFFFE, 1'b0, 1, 16'hFFFE, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("wrap_dn", {16'd0, count}, {16'd0, seq_dn[i]});
    end
    step();
    chk("wrap_dn_done", {31'd0, done}, 32'd1);
    chk("wrap_dn_grant", {31'd0, grant_id}, 32'd1);
    step();

    // Zero-step task: done at T+3 and the count stays put.
    issue(1'b0, 16'h0010, 16'h0010, 1'b1, 1, 16'h0010, 1'b0);
    step();
    chk("zero_count", {16'd0, count}, 32'h10);
    chk("zero_nodone", {31'd0, done}, 32'd0);
    step();
    chk("zero_done", {31'd0, done}, 32'd1);
    step();
    chk("zero_idle", {31'd0, busy}, 32'd0);
    chk("zero_hold", {16'd0, count}, 32'h10);

    // Pause at 4 for three cycles, then abort at 7.
    issue(1'b0, 16'h0000, 16'd100, 1'b1, 1, 16'h0007, 1'b1);
    wait_count(16'h0004);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("pause_hold", {16'd0, count}, 32'h4);
    end
    pause = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("pause_resume", {16'd0, count}, 32'd5 + i);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_done", {31'd0, done}, 32'd1);
    chk("abort_flag", {31'd0, done_aborted}, 32'd1);
    chk("abort_count", {16'd0, count}, 32'h7);
    step();
    chk("abort_idle", {31'd0, busy}, 32'd0);
    chk("abort_hold", {16'd0, count}, 32'h7);

    // Reset mid-task: no done, and a lone req1 is granted afterwards.
    issue(1'b0, 16'h0000, 16'd100, 1'b1, 0, 16'h0000, 1'b0);
    wait_count(16'h0003);
    reset = 1'b1;
    req1_start = 16'h0020; req1_end = 16'h0021; req1_up = 1'b1; req1_valid = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst_count", {16'd0, count}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_done", {31'd0, done}, 32'd0);
    #1;
    chk("mrst_ready1", {31'd0, req1_ready}, 32'd1);
    chk("mrst_ready0", {31'd0, req0_ready}, 32'd0);
    sb.push_back('{1'b1, 16'h0021, 1'b0});
    step();
    req1_valid = 1'b0;
    wait_idle();
    chk("mrst_grant", {31'd0, grant_id}, 32'd1);
    chk("mrst_final", {16'd0, count}, 32'h21);

    step();
    chk("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_task_scheduler.md
Name: count_task_scheduler

Overview:
- Shares one 16-bit up/down counter datapath between two requesters.
- Each requester submits a counting task: a start value, an end value and a direction. The block arbitrates round-robin between requesters.
- For the granted task it loads the counter and steps it until it reaches the end value, or until the task is aborted, then pulses done.
- Sits between task-issuing logic and the shared counter used as a programmable interval/sequence timer.

Parameters:
- WIDTH, 16, counter and task-value width; all count arithmetic is modulo 2^WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has a task pending.
- req0_ready  output  1  requester 0's task is accepted this cycle.
- req0_start  input  WIDTH  task start value, requester 0.
- req0_end  input  WIDTH  task end value, requester 0.
- req0_up  input  1  1 = count up, 0 = count down, requester 0.
- req1_valid  input  1  requester 1 has a task pending.
- req1_ready  output  1  requester 1's task is accepted this cycle.
- req1_start  input  WIDTH  task start value, requester 1.
- req1_end  input  WIDTH  task end value, requester 1.
- req1_up  input  1  direction, requester 1.
- pause  input  1  holds the count while high (RUN state only).
- abort  input  1  terminates the current task.
- busy  output  1  a task is in progress (state != IDLE).
- grant_id  output  1  requester owning the current or last task.
- count  output  WIDTH  current counter value.
- done  output  1  one-cycle pulse at task end.
- done_aborted  output  1  valid with done; 1 = task ended by abort.

Behaviour:
- Reset (synchronous, dominates all other inputs), all registered:
  - state = IDLE, count = 0, done = 0, done_aborted = 0, grant_id = 0.
  - last_grant = 1, so requester 0 wins first.
  - Reset mid-task discards the task with no done pulse.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If exactly one reqN_valid is high, that requester is selected.
  - If both are high, the requester != last_grant is selected.
  - reqN_ready is combinational: high only in IDLE for the selected requester, and at most one ready is high.
  - On handshake (valid & ready): latch start/end/up, set grant_id = N and last_grant = N, go to LOAD.
  - The requester must hold its fields stable while valid is high.
- LOAD: count <= latched start; go to RUN. pause does not affect LOAD.
- RUN, one action per cycle, priority order:
  - abort: go to DONE with aborted.
  - count == end: go to DONE, not aborted.
  - pause: hold count.
  - otherwise: count <= count + 1 (up) or count - 1 (down), wrapping modulo 2^WIDTH.
- Wrap-around is legal. An up task with end < start counts through the maximum value to 0 and on to end, taking (end - start) mod 2^WIDTH steps. Down tasks are symmetric.
- start == end is a zero-step task: one RUN cycle, then DONE.
- DONE:
  - done = 1 and done_aborted is valid for exactly this cycle; otherwise both are 0.
  - Next state is IDLE.
  - count holds its final value through DONE and IDLE until the next LOAD.
- abort is ignored in IDLE and DONE. In LOAD, abort takes effect on the first RUN cycle.
- Latency, with the handshake in cycle T and N = step distance:
  - LOAD in T+1.
  - count == start first visible in T+2.
  - count == end in T+2+N, assuming no pause.
  - done in T+3+N.
  - IDLE in T+4+N, where a new handshake may occur in that same cycle.
  - Each paused RUN cycle adds one cycle.
- grant_id and latched task fields are stable from LOAD through DONE.
- Round-robin fairness: with both requesters continuously valid, grants alternate 0, 1, 0, 1, ...

Test Plan:
- Reset, then req0 {start=0x0005, end=0x0008, up=1}: req0_ready in the first cycle; count goes 5, 6, 7, 8; done=1, done_aborted=0 at T+6; grant_id=0.
- Both valid from reset, each with 2-step tasks: grants are req0, then req1, then req0; the req1 handshake occurs in the IDLE cycle right after req0's done.
- req1 {start=0xFFFE, end=0x0001, up=1}: count goes FFFE, FFFF, 0000, 0001; done at T+6. Repeat down {0x0001 → 0xFFFE}: count goes 1, 0, FFFF, FFFE.
- req0 {start=0x0010, end=0x0010}: done at T+3; count stays 0x0010.
- req0 {0 → 100, up}, pause high for 3 cycles at count=4, then abort at count=7: count holds at 4 for 3 cycles; abort is seen while count=7, done=1 with done_aborted=1 the next cycle; count stays 7.
- Assert reset in RUN at count=3: the next cycle shows count=0, busy=0, done=0; a pending req1 is granted, since last_grant=1 gives requester 0 priority only when both are valid.
